display_scan_mux: RTL and testbench

- Time-multiplexing scan controller for the 00-99 scoreboard's common-anode seven-segment display.
- Sits between the BCD up/down counter and the hex-to-seven-segment converter.
- Latches the counter's digit vector into a tear-free shadow register and cycles the anode enables one digit at a time.
- Presents the active digit's 4-bit code to the converter, with dead-time ghost suppression and optional leading-zero blanking.

---
 rtl/display_scan_mux_if.sv | 31 +++
 rtl/display_scan_mux.sv | 131 +++++++++++++
 tb/tb_display_scan_mux.sv | 134 +++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_mux_if
// Purpose  : Bus bundle between the scoreboard counter/converter side and the
//            seven-segment scan multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface display_scan_mux_if #(
  parameter int NUM_DIGITS  = 2,
  parameter int DATA_WIDTH1 = 4
);
  logic [NUM_DIGITS*DATA_WIDTH1-1:0] i_digits;
  logic                              i_load;
  logic                              i_lzb_en;
  logic [DATA_WIDTH1-1:0]            o_hex;
  logic [NUM_DIGITS-1:0]             o_anode;
  logic                              o_scan_tick;

  // Digit source / display sink side
  modport master (
    output i_digits, i_load, i_lzb_en,
    input  o_hex, o_anode, o_scan_tick
  );

  // Scan multiplexer side
  modport slave (
    input  i_digits, i_load, i_lzb_en,
    output o_hex, o_anode, o_scan_tick
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_mux
// Purpose  : Time-multiplexed anode scan for a common-anode seven-segment
//            display with tear-free shadowing, dead-time ghost suppression
//            and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int DATA_WIDTH1 = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  display_scan_mux_if.slave     bus
);

  localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_vec_w = NUM_DIGITS * DATA_WIDTH1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_dead     = c_cnt_w'(DEAD_CYCLES);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  // Counters hold the position (slot, cycle) the next clock edge presents.
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_idx_w-1:0]     r_idx;
  // Cleared by reset so the very first edge is not mistaken for a frame end.
  logic                   r_run;
  logic [c_vec_w-1:0]     r_staging;
  logic [c_vec_w-1:0]     r_display;
  logic                   r_pending;

  logic                   w_boundary;
  logic [c_vec_w-1:0]     w_disp_next;
  logic [DATA_WIDTH1-1:0] w_hex_next;
  logic [NUM_DIGITS-1:0]  w_anode_next;

  // The cycle ending at this edge was the last cycle of the final slot.
  assign w_boundary = r_run && (r_cnt == '0) && (r_idx == '0);

  // Display value for the coming frame: a load on the boundary cycle wins
  // over anything already staged.
  always_comb begin
    w_disp_next = r_display;
    if (w_boundary) begin
      if (bus.i_load) begin
        w_disp_next = bus.i_digits;
      end else if (r_pending) begin
        w_disp_next = r_staging;
      end
    end
  end

  // Select the scanned digit, decide blanking and build the anode pattern.
  always_comb begin
    logic w_upper_zero;
    logic w_blank;
    w_upper_zero = 1'b1;
    w_blank      = 1'b0;
    w_hex_next   = '0;
    w_anode_next = '1;
    // Walk from the most significant digit down so w_upper_zero means
    // "this digit and every digit above it are zero".
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero &&
                     (w_disp_next[k*DATA_WIDTH1 +: DATA_WIDTH1] == '0);
      if (r_idx == c_idx_w'(k)) begin
        w_hex_next = w_disp_next[k*DATA_WIDTH1 +: DATA_WIDTH1];
        w_blank    = (k != 0) && bus.i_lzb_en && w_upper_zero;
        if ((r_cnt >= c_dead) && !w_blank) begin
          w_anode_next[k] = 1'b0;
        end
      end
    end
  end

  // Staging capture and frame-aligned transfer into the display shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_staging <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.i_load) begin
        r_staging <= bus.i_digits;
      end
      r_display <= w_disp_next;
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (bus.i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Slot cycle counter and digit index advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Registered outputs toward the converter and the anode drivers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_hex       <= '0;
      bus.o_anode     <= '1;
      bus.o_scan_tick <= 1'b0;
    end else begin
      bus.o_hex       <= w_hex_next;
      bus.o_anode     <= w_anode_next;
      bus.o_scan_tick <= (r_cnt == '0) && (r_idx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_mux
// Purpose  : Directed self-checking bench for display_scan_mux
//            (2 digits, 8-cycle slots, 2 dead cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_mux;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  display_scan_mux_if #(.NUM_DIGITS(2), .DATA_WIDTH1(4)) bus_if ();

  display_scan_mux #(
    .NUM_DIGITS (2),
    .DATA_WIDTH1(4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: observe at the falling edge, drop any load strobe, compare.
  task automatic check_cycle(input logic [7:0] disp, input logic lzb);
    int         pos;
    int         slot;
    int         c;
    logic [3:0] dig;
    logic       blank;
    logic [1:0] anode;
    @(negedge clk);
    bus_if.i_load = 1'b0;
    pos   = cyc % 16;
    slot  = pos / 8;
    c     = pos % 8;
    dig   = (slot == 1) ? disp[7:4] : disp[3:0];
    blank = (slot == 1) && lzb && (disp[7:4] == 4'h0);
    anode = (c < 2 || blank) ? 2'b11 : ((slot == 1) ? 2'b01 : 2'b10);
    check($sformatf("hex@%0d", cyc),   {28'd0, bus_if.o_hex},      {28'd0, dig});
    check($sformatf("anode@%0d", cyc), {30'd0, bus_if.o_anode},    {30'd0, anode});
    check($sformatf("tick@%0d", cyc),  {31'd0, bus_if.o_scan_tick}, {31'd0, (pos == 0)});
    cyc++;
  endtask

  // Check ncyc cycles of a frame showing disp; optionally pulse loads at
  // given in-frame cycle positions.
  task automatic run_frame(input logic [7:0] disp, input logic lzb, input int ncyc,
                           input int ld_at, input logic [7:0] ld_val,
                           input int ld2_at, input logic [7:0] ld2_val);
    bus_if.i_lzb_en = lzb;
    for (int i = 0; i < ncyc; i++) begin
      check_cycle(disp, lzb);
      if (i == ld_at) begin
        bus_if.i_load   = 1'b1;
        bus_if.i_digits = ld_val;
      end else if (i == ld2_at) begin
        bus_if.i_load   = 1'b1;
        bus_if.i_digits = ld2_val;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus_if.i_digits = 8'h00;
    bus_if.i_load   = 1'b0;
    bus_if.i_lzb_en = 1'b0;

    // Held in reset
    repeat (3) @(negedge clk);
    check("rst_anode", {30'd0, bus_if.o_anode},     32'h3);
    check("rst_hex",   {28'd0, bus_if.o_hex},       32'h0);
    check("rst_tick",  {31'd0, bus_if.o_scan_tick}, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    // Empty frame showing "0"; load 0x42 during slot 0
    run_frame(8'h00, 1'b0, 16, 3, 8'h42, -1, 8'h00);
    // 0x42 appears; loads 0x17 then 0x93 in the same frame
    run_frame(8'h42, 1'b0, 16, 2, 8'h17, 9, 8'h93);
    // Only 0x93 shows; load 0x55 on the frame-boundary cycle
    run_frame(8'h93, 1'b0, 16, 15, 8'h55, -1, 8'h00);
    // 0x55 appears immediately; queue 0x05
    run_frame(8'h55, 1'b0, 16, 4, 8'h05, -1, 8'h00);
    // 0x05 with blanking: tens slot dark
    run_frame(8'h05, 1'b1, 16, -1, 8'h00, -1, 8'h00);
    // 0x05 without blanking: tens slot lit with 0; queue 0x00
    run_frame(8'h05, 1'b0, 16, 6, 8'h00, -1, 8'h00);
    // 0x00 with blanking: units still lit with 0; queue 0xA7
    run_frame(8'h00, 1'b1, 16, 3, 8'hA7, -1, 8'h00);
    // Non-decimal code passes through and is not blanked; queue 0x31
    run_frame(8'hA7, 1'b1, 16, 12, 8'h31, -1, 8'h00);
    // Up to slot 1 cycle 4 with a pending load of 0x68
    run_frame(8'h31, 1'b0, 13, 2, 8'h68, -1, 8'h00);

    // Asynchronous reset between clock edges
    #1 rst_n = 1'b0;
    #1;
    check("async_anode", {30'd0, bus_if.o_anode},     32'h3);
    check("async_hex",   {28'd0, bus_if.o_hex},       32'h0);
    check("async_tick",  {31'd0, bus_if.o_scan_tick}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Pending 0x68 discarded: two frames of 0
    run_frame(8'h00, 1'b0, 32, -1, 8'h00, -1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
